// File: rtl/ddco_pkg.sv
// Shared definitions for the truth-table sweeper.
// Contents:
//   state_t     sweep FSM states (IDLE, HOLD, SAMPLE, DONE)
//   MAX_INPUTS  largest supported driven input width
//   MAX_SETTLE  largest supported settle-cycle count
//   CNT_W       width of the settle counter, sized to hold MAX_SETTLE
//   mask_width  number of minterm bits for a given input count
package ddco_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int MAX_INPUTS = 6;
  localparam int MAX_SETTLE = 255;
  localparam int CNT_W      = $clog2(MAX_SETTLE + 1);

  // One minterm bit per input combination.
  function automatic int mask_width(input int n_inputs);
    return 32'sd1 << n_inputs;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// settle_counter: loadable down-counter that times the settle window per code.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (count cleared)
//   load        load load_value this cycle (takes priority over dec)
//   load_value  value to load
//   dec         decrement by one; saturates at zero
//   zero        high while the count is zero
module settle_counter
  import ddco_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: load, saturating decrement, or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input code of an external combinational
// function, waits a settle window per code, samples the function output and
// returns the captured minterm mask (bit k = f(k)).
// Parameters:
//   N_INPUTS       driven input width, 1..6; mask is 2**N_INPUTS bits
//   SETTLE_CYCLES  extra hold cycles per code before sampling, 0..255
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     sweep request, accepted only while idle
//   y_in      output of the function under test (synchronous to clk)
//   bcd_out   driven input code, MSB = first function input
//   busy      high from the cycle after start acceptance until done
//   done      one-cycle pulse when minterms is valid
//   minterms  captured mask
// Optional build macro MISMATCH_CHECK_EN adds:
//   expected  reference mask, sampled on start acceptance
//   mismatch  registered (minterms != expected), set with done, held until
//             the next accepted start or rst
module truth_table_sweeper
  import ddco_pkg::*;
#(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     y_in,
  output logic [N_INPUTS-1:0]      bcd_out,
  output logic                     busy,
  output logic                     done,
`ifdef MISMATCH_CHECK_EN
  input  logic [(2**N_INPUTS)-1:0] expected,
  output logic                     mismatch,
`endif
  output logic [(2**N_INPUTS)-1:0] minterms
);

  localparam int                  MASK_W   = mask_width(N_INPUTS);
  localparam logic [N_INPUTS-1:0] IDX_LAST = {N_INPUTS{1'b1}};

  state_t              state_r, state_next;
  logic [N_INPUTS-1:0] idx_r, idx_next;
  logic                busy_r, busy_next;
  logic                done_r, done_next;
  logic [MASK_W-1:0]   mask_r, mask_next;
  logic                cnt_load_s, cnt_dec_s, cnt_zero_s;
`ifdef MISMATCH_CHECK_EN
  logic [MASK_W-1:0]   expected_r, expected_next;
  logic                mismatch_r, mismatch_next;
`endif

  settle_counter u_settle (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load_s),
    .load_value (CNT_W'(SETTLE_CYCLES)),
    .dec        (cnt_dec_s),
    .zero       (cnt_zero_s)
  );

  // Next-state and next-register values for the sweep FSM.
  always_comb begin
    state_next = state_r;
    idx_next   = idx_r;
    busy_next  = busy_r;
    done_next  = 1'b0;
    mask_next  = mask_r;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
`ifdef MISMATCH_CHECK_EN
    expected_next = expected_r;
    mismatch_next = mismatch_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next = HOLD;
          idx_next   = {N_INPUTS{1'b0}};
          busy_next  = 1'b1;
          mask_next  = {MASK_W{1'b0}};
          cnt_load_s = 1'b1;
`ifdef MISMATCH_CHECK_EN
          expected_next = expected;
          mismatch_next = 1'b0;
`endif
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        // The counter was loaded on entry, so HOLD spans SETTLE_CYCLES+1 cycles.
        if (cnt_zero_s) begin
          state_next = SAMPLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      SAMPLE: begin
        mask_next[idx_r] = y_in;
        // Terminal code is checked before incrementing so idx never wraps.
        if (idx_r == IDX_LAST) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
`ifdef MISMATCH_CHECK_EN
          mismatch_next = (mask_next != expected_r);
`endif
        end else begin
          state_next = HOLD;
          idx_next   = idx_r + N_INPUTS'(1);
          cnt_load_s = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // FSM state and all output-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= {N_INPUTS{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      mask_r  <= {MASK_W{1'b0}};
`ifdef MISMATCH_CHECK_EN
      expected_r <= {MASK_W{1'b0}};
      mismatch_r <= 1'b0;
`endif
    end else begin
      state_r <= state_next;
      idx_r   <= idx_next;
      busy_r  <= busy_next;
      done_r  <= done_next;
      mask_r  <= mask_next;
`ifdef MISMATCH_CHECK_EN
      expected_r <= expected_next;
      mismatch_r <= mismatch_next;
`endif
    end
  end

  assign bcd_out  = idx_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign minterms = mask_r;
`ifdef MISMATCH_CHECK_EN
  assign mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE_CYCLES=1 and 0, N_INPUTS=3),
// each fed by a function of its own bcd_out chosen by the bench.
module tb_truth_table_sweeper;

  localparam int F_ANDOR = 0;  // C'D + BD
  localparam int F_ONE   = 1;
  localparam int F_XOR   = 2;  // B ^ C ^ D
  localparam int F_ZERO  = 3;
  localparam int F_TABLE = 4;  // arbitrary truth table

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       y_a, y_b;
  logic [2:0] bcd_a, bcd_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [7:0] mint_a, mint_b;
  logic [7:0] exp_in_a, exp_in_b;
  logic       mm_a, mm_b;
  int         fid_a, fid_b;
  logic [7:0] tt_a, tt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Reference behaviour of each function, from its boolean definition.
  function automatic logic f_eval(input int fid, input int k, input logic [7:0] tt);
    logic b, c, d;
    b = k[2];
    c = k[1];
    d = k[0];
    case (fid)
      F_ANDOR: return (!c && d) || (b && d);
      F_ONE:   return 1'b1;
      F_XOR:   return b ^ c ^ d;
      F_ZERO:  return 1'b0;
      default: return tt[k[2:0]];
    endcase
  endfunction

  function automatic logic [7:0] model_mask(input int fid, input logic [7:0] tt);
    logic [7:0] m;
    m = 8'd0;
    for (int k = 0; k < 8; k++) m[k] = f_eval(fid, k, tt);
    return m;
  endfunction

  assign y_a = f_eval(fid_a, int'(bcd_a), tt_a);
  assign y_b = f_eval(fid_b, int'(bcd_b), tt_b);

  truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .y_in(y_a), .bcd_out(bcd_a),
    .busy(busy_a), .done(done_a),
`ifdef MISMATCH_CHECK_EN
    .expected(exp_in_a), .mismatch(mm_a),
`endif
    .minterms(mint_a)
  );

  truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .y_in(y_b), .bcd_out(bcd_b),
    .busy(busy_b), .done(done_b),
`ifdef MISMATCH_CHECK_EN
    .expected(exp_in_b), .mismatch(mm_b),
`endif
    .minterms(mint_b)
  );

`ifndef MISMATCH_CHECK_EN
  assign mm_a = 1'b0;
  assign mm_b = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic get(input int which, output logic [2:0] bcd, output logic busy,
                     output logic done, output logic [7:0] m, output logic mm);
    if (which == 0) begin
      bcd = bcd_a; busy = busy_a; done = done_a; m = mint_a; mm = mm_a;
    end else begin
      bcd = bcd_b; busy = busy_b; done = done_b; m = mint_b; mm = mm_b;
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v;
    else start_b = v;
  endtask

  // Full sweep from the idle state; called at a negedge, returns at a negedge.
  // Every code must be held exactly SETTLE+2 cycles and done must rise on the
  // (8*(SETTLE+2)+1)-th edge counting the accepting edge as the first.
  task automatic run_sweep(input int which, input int fid, input logic [7:0] tt,
                           input logic [7:0] exp_mask, input logic [7:0] exp_in,
                           input int mid_pulse, input bit done_pulse);
    int hold, len;
    logic [2:0] bcd; logic busy, done, mm; logic [7:0] m;
    hold = (which == 0) ? 3 : 2;
    len  = 8 * hold;
    if (which == 0) begin fid_a = fid; tt_a = tt; exp_in_a = exp_in; end
    else begin fid_b = fid; tt_b = tt; exp_in_b = exp_in; end
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    for (int c = 0; c < len; c++) begin
      get(which, bcd, busy, done, m, mm);
      chk($sformatf("bcd_c%0d", c), 32'(bcd), 32'(c / hold));
      chk($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("done_c%0d", c), 32'(done), 32'd0);
`ifdef MISMATCH_CHECK_EN
      chk($sformatf("mm_sweep_c%0d", c), 32'(mm), 32'd0);
`endif
      set_start(which, (c == mid_pulse) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    get(which, bcd, busy, done, m, mm);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("bcd_at_done", 32'(bcd), 32'd7);
    chk("mask_at_done", 32'(m), 32'(exp_mask));
`ifdef MISMATCH_CHECK_EN
    chk("mismatch_at_done", 32'(mm), 32'(exp_mask != exp_in));
`endif
    set_start(which, done_pulse);
    @(negedge clk);
    set_start(which, 1'b0);
    for (int c = 0; c < 3; c++) begin
      get(which, bcd, busy, done, m, mm);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_mask", 32'(m), 32'(exp_mask));
      chk("idle_bcd", 32'(bcd), 32'd7);
`ifdef MISMATCH_CHECK_EN
      chk("idle_mismatch", 32'(mm), 32'(exp_mask != exp_in));
`endif
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
    chk({tag, "_done_a"}, 32'(done_a), 32'd0);
    chk({tag, "_mask_a"}, 32'(mint_a), 32'd0);
    chk({tag, "_bcd_a"}, 32'(bcd_a), 32'd0);
    chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
    chk({tag, "_done_b"}, 32'(done_b), 32'd0);
    chk({tag, "_mask_b"}, 32'(mint_b), 32'd0);
    chk({tag, "_bcd_b"}, 32'(bcd_b), 32'd0);
`ifdef MISMATCH_CHECK_EN
    chk({tag, "_mm_a"}, 32'(mm_a), 32'd0);
    chk({tag, "_mm_b"}, 32'(mm_b), 32'd0);
`endif
  endtask

  typedef struct {
    int         which;
    int         fid;
    logic [7:0] exp_in;
    logic [7:0] exp_mask;
  } vec_t;

  initial begin
    vec_t vecs[8];
    logic [7:0] tt;
    int which;

    vecs[0] = '{which: 0, fid: F_ANDOR, exp_in: 8'hA2, exp_mask: 8'hA2};
    vecs[1] = '{which: 0, fid: F_ANDOR, exp_in: 8'hA3, exp_mask: 8'hA2};
    vecs[2] = '{which: 1, fid: F_ONE,   exp_in: 8'hFF, exp_mask: 8'hFF};
    vecs[3] = '{which: 0, fid: F_XOR,   exp_in: 8'h96, exp_mask: 8'h96};
    vecs[4] = '{which: 1, fid: F_XOR,   exp_in: 8'h00, exp_mask: 8'h96};
    vecs[5] = '{which: 1, fid: F_ZERO,  exp_in: 8'h00, exp_mask: 8'h00};
    vecs[6] = '{which: 0, fid: F_ONE,   exp_in: 8'h7F, exp_mask: 8'hFF};
    vecs[7] = '{which: 1, fid: F_ANDOR, exp_in: 8'hA2, exp_mask: 8'hA2};

    rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    fid_a = F_ONE; fid_b = F_ONE; tt_a = 8'h00; tt_b = 8'h00;
    exp_in_a = 8'h00; exp_in_b = 8'h00;

    // Reset held 3 cycles with start high: nothing may start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_state($sformatf("reset%0d", i));
    end
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    chk_reset_state("post_reset");

    // Table-driven sweeps.
    foreach (vecs[i]) begin
      run_sweep(vecs[i].which, vecs[i].fid, 8'h00, vecs[i].exp_mask, vecs[i].exp_in, -1, 1'b0);
    end

    // Start pulsed mid-sweep and during the done cycle: both ignored.
    run_sweep(0, F_ANDOR, 8'h00, 8'hA2, 8'hA2, 10, 1'b1);
    run_sweep(1, F_XOR, 8'h00, 8'h96, 8'h96, 15, 1'b1);

    // Reset mid-sweep at code 4, then a clean XOR sweep.
    fid_a = F_XOR;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 12; c++) @(negedge clk);
    chk("abort_bcd4", 32'(bcd_a), 32'd4);
    chk("abort_partial", 32'(mint_a), 32'h06);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("midrst");
    @(negedge clk);
    chk_reset_state("midrst_idle");
    run_sweep(0, F_XOR, 8'h00, 8'h96, 8'h96, -1, 1'b0);

    // Random truth tables against the model.
    for (int r = 0; r < 8; r++) begin
      tt = 8'($urandom_range(0, 255));
      which = r % 2;
      run_sweep(which, F_TABLE, tt, model_mask(F_TABLE, tt), 8'($urandom_range(0, 255)),
                int'($urandom_range(0, 23)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
